mem_stage: RTL and testbench

- Memory-access stage of the 5-step CPU; consumes the EX stage outputs `mem_ir`, `reg_C`, `smdr1` and `dw`.
- LOAD and STORE instructions run a req/ack transaction on the external data-memory bus. All other instructions pass straight through to write-back.
- While a transaction is outstanding the stage holds `stall` high, so the sequencer freezes the pipeline.

---
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: runs a req/ack data-bus transaction for LOAD/STORE and
// passes every other instruction straight through to write-back.
module mem_stage #(
  parameter logic [4:0]  OP_LOAD  = 5'b00010,
  parameter logic [4:0]  OP_STORE = 5'b00011,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stage_en,
  input  logic [15:0] mem_ir,
  input  logic [15:0] reg_C,
  input  logic [15:0] smdr1,
  input  logic        dw,
  output logic [15:0] d_addr,
  output logic [15:0] d_wdata,
  output logic        d_we,
  output logic        d_req,
  input  logic [15:0] d_rdata,
  input  logic        d_ack,
  output logic [15:0] wb_ir,
  output logic [15:0] reg_C1,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Counter value on the last wait edge before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] ir_lat, ir_lat_n;
  logic [15:0] d_addr_n, d_wdata_n, wb_ir_n, reg_C1_n;
  logic        d_we_n, d_req_n, stall_n, bus_err_n;
  logic        is_load, is_store;

  assign is_load  = (mem_ir[15:11] == OP_LOAD);
  assign is_store = (mem_ir[15:11] == OP_STORE) && dw;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ir_lat_n  = ir_lat;
    d_addr_n  = d_addr;
    d_wdata_n = d_wdata;
    d_we_n    = d_we;
    d_req_n   = d_req;
    stall_n   = stall;
    bus_err_n = bus_err;
    wb_ir_n   = wb_ir;
    reg_C1_n  = reg_C1;
    case (state)
      IDLE: begin
        if (stage_en) begin
          if (is_load || is_store) begin
            ir_lat_n = mem_ir;
            d_addr_n = reg_C;
            d_we_n   = is_store;
            if (is_store) d_wdata_n = smdr1;
            d_req_n  = 1'b1;
            stall_n  = 1'b1;
            cnt_n    = '0;
            state_n  = ACCESS;
          end else begin
            wb_ir_n  = mem_ir;
            reg_C1_n = reg_C;
          end
        end
      end
      ACCESS: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (d_ack) begin
          d_req_n  = 1'b0;
          d_we_n   = 1'b0;
          stall_n  = 1'b0;
          wb_ir_n  = ir_lat;
          reg_C1_n = d_we ? d_addr : d_rdata;
          state_n  = IDLE;
        end else if (cnt == CNT_LAST) begin
          d_req_n   = 1'b0;
          d_we_n    = 1'b0;
          stall_n   = 1'b0;
          bus_err_n = 1'b1;
          wb_ir_n   = '0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ir_lat  <= '0;
      d_addr  <= '0;
      d_wdata <= '0;
      d_we    <= 1'b0;
      d_req   <= 1'b0;
      stall   <= 1'b0;
      bus_err <= 1'b0;
      wb_ir   <= '0;
      reg_C1  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ir_lat  <= ir_lat_n;
      d_addr  <= d_addr_n;
      d_wdata <= d_wdata_n;
      d_we    <= d_we_n;
      d_req   <= d_req_n;
      stall   <= stall_n;
      bus_err <= bus_err_n;
      wb_ir   <= wb_ir_n;
      reg_C1  <= reg_C1_n;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: write-back results go through a scoreboard
// queue checked by a monitor; bus-side signals are checked inline.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stage_en = 1'b0;
  logic [15:0] mem_ir = '0;
  logic [15:0] reg_C = '0;
  logic [15:0] smdr1 = '0;
  logic        dw = 1'b0;
  logic [15:0] d_addr, d_wdata, wb_ir, reg_C1;
  logic        d_we, d_req, stall, bus_err;
  logic [15:0] d_rdata = '0;
  logic        d_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] res;
    logic        err;
  } wb_t;

  wb_t sb[$];

  mem_stage #(.OP_LOAD(5'b00010), .OP_STORE(5'b00011), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .stage_en(stage_en), .mem_ir(mem_ir),
    .reg_C(reg_C), .smdr1(smdr1), .dw(dw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_we(d_we), .d_req(d_req), .d_rdata(d_rdata), .d_ack(d_ack),
    .wb_ir(wb_ir), .reg_C1(reg_C1), .stall(stall), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a write-back event is stall falling or a change of the result regs.
  wb_t  prev;
  logic prev_stall;
  initial begin
    prev = '0;
    prev_stall = 1'b0;
  end
  always @(negedge clock) begin
    wb_t cur;
    wb_t exp;
    cur = '{ir: wb_ir, res: reg_C1, err: bus_err};
    if (reset) begin
      prev       = cur;
      prev_stall = stall;
    end else begin
      if ((prev_stall && !stall) || (cur != prev)) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", {15'd0, cur}, '0);
        end else begin
          exp = sb.pop_front();
          chk("wb_ir", {16'd0, cur.ir}, {16'd0, exp.ir});
          chk("reg_C1", {16'd0, cur.res}, {16'd0, exp.res});
          chk("bus_err", {31'd0, cur.err}, {31'd0, exp.err});
        end
      end
      prev       = cur;
      prev_stall = stall;
    end
  end

  task automatic issue(input logic [15:0] ir, input logic [15:0] c,
                       input logic [15:0] sd, input logic w);
    @(negedge clock);
    mem_ir   = ir;
    reg_C    = c;
    smdr1    = sd;
    dw       = w;
    stage_en = 1'b1;
  endtask

  initial begin
    // Reset and reset values
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_outs", {wb_ir, reg_C1}, '0);
    chk("rst_bus", {d_addr, d_wdata}, '0);
    chk("rst_flags", {28'd0, d_we, d_req, stall, bus_err}, '0);

    // Pass-through
    issue(16'h5805, 16'h1234, 16'h0000, 1'b0);
    sb.push_back('{ir: 16'h5805, res: 16'h1234, err: 1'b0});
    @(negedge clock);
    stage_en = 1'b0;
    chk("pt_req_stall", {30'd0, d_req, stall}, '0);

    // Load with 3 wait cycles; stage_en and inputs changed during ACCESS are ignored
    issue(16'h1000, 16'h0040, 16'h0000, 1'b0);
    sb.push_back('{ir: 16'h1000, res: 16'hBEEF, err: 1'b0});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      mem_ir = 16'h1000;
      reg_C  = 16'h7777;
      chk("ld_req", {31'd0, d_req}, 32'd1);
      chk("ld_addr", {16'd0, d_addr}, 32'h0040);
      chk("ld_we_stall", {30'd0, d_we, stall}, 32'd1);
      if (i == 4) begin
        d_ack   = 1'b1;
        d_rdata = 16'hBEEF;
      end
    end
    @(negedge clock);
    d_ack = 1'b0;
    stage_en = 1'b0;
    chk("ld_done", {30'd0, d_req, stall}, '0);

    // Store, zero-wait
    issue(16'h1800, 16'h0010, 16'hA5A5, 1'b1);
    sb.push_back('{ir: 16'h1800, res: 16'h0010, err: 1'b0});
    @(negedge clock);
    stage_en = 1'b0;
    chk("st_req_we", {30'd0, d_req, d_we}, 32'd3);
    chk("st_wdata", {16'd0, d_wdata}, 32'h0000A5A5);
    d_ack = 1'b1;
    @(negedge clock);
    d_ack = 1'b0;
    chk("st_done", {29'd0, d_req, d_we, stall}, '0);

    // Store opcode with dw=0 is a pass-through
    issue(16'h1800, 16'h0077, 16'h5555, 1'b0);
    sb.push_back('{ir: 16'h1800, res: 16'h0077, err: 1'b0});
    @(negedge clock);
    stage_en = 1'b0;
    chk("st_nodw", {30'd0, d_req, stall}, '0);

    // Ack on the timeout edge: normal completion
    issue(16'h1000, 16'h0080, 16'h0000, 1'b0);
    sb.push_back('{ir: 16'h1000, res: 16'hCAFE, err: 1'b0});
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      stage_en = 1'b0;
      chk("ackto_req", {31'd0, d_req}, 32'd1);
      if (i == 15) begin
        d_ack   = 1'b1;
        d_rdata = 16'hCAFE;
      end
    end
    @(negedge clock);
    d_ack = 1'b0;
    chk("ackto_done", {30'd0, d_req, bus_err}, '0);

    // Timeout: no ack at all
    issue(16'h1000, 16'h0090, 16'h0000, 1'b0);
    sb.push_back('{ir: 16'h0000, res: 16'hCAFE, err: 1'b1});
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      stage_en = 1'b0;
      chk("to_req", {30'd0, d_req, bus_err}, 32'd2);
    end
    @(negedge clock);
    chk("to_done", {29'd0, d_req, stall, bus_err}, 32'd1);
    repeat (3) @(negedge clock);
    issue(16'h5805, 16'h4321, 16'h0000, 1'b0);
    sb.push_back('{ir: 16'h5805, res: 16'h4321, err: 1'b1});
    @(negedge clock);
    stage_en = 1'b0;
    chk("to_sticky", {31'd0, bus_err}, 32'd1);

    // Reset two cycles into a load: req/stall drop without a clock edge
    issue(16'h1000, 16'h00A0, 16'h0000, 1'b0);
    repeat (2) begin
      @(negedge clock);
      stage_en = 1'b0;
      chk("rm_req", {31'd0, d_req}, 32'd1);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("rm_async", {29'd0, d_req, stall, bus_err}, '0);
    @(negedge clock);
    #2 reset = 1'b0;

    // Stray ack in IDLE changes nothing
    @(negedge clock);
    d_ack   = 1'b1;
    d_rdata = 16'hFFFF;
    repeat (2) @(negedge clock);
    d_ack = 1'b0;
    chk("stray_outs", {wb_ir, reg_C1}, '0);
    chk("stray_flags", {28'd0, d_we, d_req, stall, bus_err}, '0);
    repeat (2) @(negedge clock);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
